// File: rtl/sram_like_to_sram_pkg.sv
// Shared constants and types for the sram-like to synchronous SRAM bridge.
package sram_like_to_sram_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT_RAM,
    ST_DELAY,
    ST_READY
  } entry_state_e;

endpackage

// File: rtl/sram_like_byte_en.sv
// Byte-lane write-enable decode from transfer size and low address bits.
// Misaligned or reserved-size writes produce no enables at all.
module sram_like_byte_en
  import sram_like_to_sram_pkg::*;
(
  input  logic       wr,
  input  logic [1:0] size,
  input  logic [1:0] addrLo,
  output logic [3:0] wen
);

  // Reads never write; aligned writes enable the lanes covered by the size.
  always_comb begin
    wen = 4'b0000;
    if (wr) begin
      case (size)
        SIZE_BYTE: wen = 4'b0001 << addrLo;
        SIZE_HALF: if (!addrLo[0]) wen = 4'b0011 << addrLo;
        SIZE_WORD: if (addrLo == 2'b00) wen = 4'b1111;
        default:   wen = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_to_sram.sv
// Bridge from an sram-like (addr_ok/data_ok) master to a one-cycle-latency
// synchronous SRAM, with a two-entry in-order completion queue.
module sram_like_to_sram
  import sram_like_to_sram_pkg::*;
#(
  parameter int RESP_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [2:0] DELAY_LOAD = 3'(RESP_DELAY);

  entry_state_e state_q [DEPTH];
  logic [2:0]   cnt_q   [DEPTH];
  logic [31:0]  data_q  [DEPTH];
  logic         isWr_q  [DEPTH];
  logic         head_q;
  logic         tail_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         data_ok_q;
  logic [31:0]  rdata_q;

  logic             accept;
  logic             retire;
  logic [3:0]       wenDec;
  logic [31:0]      headData;
  logic [DEPTH-1:0] entryDone;

  sram_like_byte_en u_byte_en (
    .wr     (wr),
    .size   (size),
    .addrLo (addr[1:0]),
    .wen    (wenDec)
  );

  // Acceptance depends only on queue space, never on the request itself.
  always_comb begin
    addr_ok   = (rst == RST_DISABLE) && (count_q < 2'(DEPTH));
    accept    = req && addr_ok;
    ram_en    = accept;
    ram_wen   = accept ? wenDec : 4'b0000;
    ram_addr  = {addr[31:2], 2'b00};
    ram_wdata = wdata;
    data_ok   = data_ok_q;
    rdata     = rdata_q;
  end

  // An entry may retire at the coming edge if it is READY, or is in its last
  // delay cycle, or (zero delay) is receiving its SRAM data right now.
  always_comb begin
    entryDone = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryDone[i] = (state_q[i] == ST_READY) ||
                     ((state_q[i] == ST_DELAY) && (cnt_q[i] == 3'd1)) ||
                     ((state_q[i] == ST_WAIT_RAM) && (DELAY_LOAD == 3'd0));
    end
  end

  // Only the head may retire; its data comes straight from the SRAM when it
  // completes in the same cycle the read data arrives.
  always_comb begin
    retire   = entryDone[head_q];
    headData = data_q[head_q];
    if (state_q[head_q] == ST_WAIT_RAM) begin
      headData = isWr_q[head_q] ? 32'h0 : ram_rdata;
    end
    count_d = count_q + {1'b0, accept} - {1'b0, retire};
  end

  // Queue entry state machines, pointers and the registered response outputs.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
        cnt_q[i]   <= 3'd0;
        data_q[i]  <= 32'h0;
        isWr_q[i]  <= 1'b0;
      end
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= retire;
      if (retire) rdata_q <= headData;
      for (int i = 0; i < DEPTH; i++) begin
        case (state_q[i])
          ST_WAIT_RAM: begin
            data_q[i] <= isWr_q[i] ? 32'h0 : ram_rdata;
            if (DELAY_LOAD == 3'd0) begin
              state_q[i] <= ST_READY;
              cnt_q[i]   <= 3'd0;
            end else begin
              state_q[i] <= ST_DELAY;
              cnt_q[i]   <= DELAY_LOAD;
            end
          end
          ST_DELAY: begin
            cnt_q[i] <= cnt_q[i] - 3'd1;
            if (cnt_q[i] == 3'd1) state_q[i] <= ST_READY;
          end
          default: ;
        endcase
        if (retire && (1'(i) == head_q)) begin
          state_q[i] <= ST_EMPTY;
          cnt_q[i]   <= 3'd0;
        end
        if (accept && (1'(i) == tail_q)) begin
          state_q[i] <= ST_WAIT_RAM;
          isWr_q[i]  <= wr;
          cnt_q[i]   <= 3'd0;
        end
      end
      head_q  <= head_q ^ retire;
      tail_q  <= tail_q ^ accept;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_like_to_sram.sv
// Directed self-checking bench: one bridge with zero response delay and one
// with a delay of three, both driven from the same master/SRAM stimulus.
module tb_sram_like_to_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ramRdata;

  logic        d0AddrOk, d0DataOk, d0RamEn;
  logic [31:0] d0Rdata, d0RamAddr, d0RamWdata;
  logic [3:0]  d0RamWen;
  logic        d3AddrOk, d3DataOk, d3RamEn;
  logic [31:0] d3Rdata, d3RamAddr, d3RamWdata;
  logic [3:0]  d3RamWen;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  sram_like_to_sram #(.RESP_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(d0AddrOk), .data_ok(d0DataOk), .rdata(d0Rdata),
    .ram_en(d0RamEn), .ram_wen(d0RamWen), .ram_addr(d0RamAddr),
    .ram_wdata(d0RamWdata), .ram_rdata(ramRdata)
  );

  sram_like_to_sram #(.RESP_DELAY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(d3AddrOk), .data_ok(d3DataOk), .rdata(d3Rdata),
    .ram_en(d3RamEn), .ram_wen(d3RamWen), .ram_addr(d3RamAddr),
    .ram_wdata(d3RamWdata), .ram_rdata(ramRdata)
  );

  // One cycle: drive inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic r, input logic rq, input logic w,
                               input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd);
    @(negedge clk);
    rst = r; req = rq; wr = w; size = sz; addr = a; wdata = wd; ramRdata = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  logic [10:0] expDataOk4;
  logic [5:0]  expAddrOk4;
  logic [31:0] expRdata4;

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
    addr = 32'h0; wdata = 32'h0; ramRdata = 32'h0;

    // Reset with a request pending: nothing may be accepted or written.
    applyStimulus(1, 1, 1, 2'd2, 32'h0, 32'hFFFF_FFFF, 32'h0);
    checkOutput("rst_addr_ok", d0AddrOk, 0);
    checkOutput("rst_ram_en", d0RamEn, 0);
    checkOutput("rst_ram_wen", d0RamWen, 0);
    applyStimulus(1, 1, 1, 2'd2, 32'h0, 32'hFFFF_FFFF, 32'h0);
    checkOutput("rst_data_ok", d0DataOk, 0);
    checkOutput("rst_rdata", d0Rdata, 0);

    // Test 1: word read at 0x10, data back two cycles later.
    applyStimulus(0, 1, 0, 2'd2, 32'h10, 32'h0, 32'h0);
    checkOutput("t1_addr_ok", d0AddrOk, 1);
    checkOutput("t1_ram_en", d0RamEn, 1);
    checkOutput("t1_ram_addr", d0RamAddr, 32'h10);
    checkOutput("t1_ram_wen", d0RamWen, 0);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF);
    checkOutput("t1_data_ok_early", d0DataOk, 0);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("t1_data_ok", d0DataOk, 1);
    checkOutput("t1_rdata", d0Rdata, 32'hDEAD_BEEF);

    // Test 2: byte write to lane 3; rdata holds its old value meanwhile.
    applyStimulus(0, 1, 1, 2'd0, 32'h13, 32'hAA00_0000, 32'h0);
    checkOutput("t2_ram_en", d0RamEn, 1);
    checkOutput("t2_ram_wen", d0RamWen, 4'b1000);
    checkOutput("t2_ram_addr", d0RamAddr, 32'h10);
    checkOutput("t2_ram_wdata", d0RamWdata, 32'hAA00_0000);
    checkOutput("t2_pulse_end", d0DataOk, 0);
    checkOutput("t2_rdata_hold", d0Rdata, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h1234_5678);
    checkOutput("t2_data_ok_early", d0DataOk, 0);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("t2_data_ok", d0DataOk, 1);
    checkOutput("t2_rdata_zero", d0Rdata, 0);

    // Test 3: eight back-to-back reads at full rate.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, (k < 8), 0, 2'd2, 32'h100 + 32'(4 * k), 32'h0,
                    (k >= 1 && k <= 8) ? 32'h1000_0000 + 32'(k - 1) : 32'h0);
      if (k < 8) checkOutput($sformatf("t3_addr_ok_%0d", k), d0AddrOk, 1);
      checkOutput($sformatf("t3_data_ok_%0d", k), d0DataOk, (k >= 2));
      if (k >= 2) checkOutput($sformatf("t3_rdata_%0d", k), d0Rdata,
                              32'h1000_0000 + 32'(k - 2));
    end

    // Test 5: misaligned word write still completes with no lanes enabled.
    applyStimulus(0, 1, 1, 2'd2, 32'h2, 32'hFFFF_FFFF, 32'h0);
    checkOutput("t5_ram_en", d0RamEn, 1);
    checkOutput("t5_ram_wen", d0RamWen, 0);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h5555_5555);
    checkOutput("t5_data_ok_early", d0DataOk, 0);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("t5_data_ok", d0DataOk, 1);
    checkOutput("t5_rdata_zero", d0Rdata, 0);

    // Test 4: delay of three, three reads requested back to back.
    applyStimulus(1, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    expDataOk4 = 11'b100_0110_0000;
    expAddrOk4 = 6'b100011;
    for (int k = 0; k < 11; k++) begin
      applyStimulus(0, (k <= 5), 0, 2'd2, 32'h20 + 32'(4 * ((k > 2) ? 2 : k)),
                    32'h0,
                    (k == 1) ? 32'hA0 : (k == 2) ? 32'hA1 : (k == 6) ? 32'hA2 : 32'h0);
      if (k <= 5) checkOutput($sformatf("t4_addr_ok_%0d", k), d3AddrOk, expAddrOk4[k]);
      checkOutput($sformatf("t4_data_ok_%0d", k), d3DataOk, expDataOk4[k]);
      expRdata4 = (k < 5) ? 32'h0 : (k < 6) ? 32'hA0 : (k < 10) ? 32'hA1 : 32'hA2;
      checkOutput($sformatf("t4_rdata_%0d", k), d3Rdata, expRdata4);
    end

    // Test 6: reset with two reads in flight discards them silently.
    applyStimulus(0, 1, 0, 2'd2, 32'h40, 32'h0, 32'h0);
    checkOutput("t6_accept0", d3RamEn, 1);
    applyStimulus(0, 1, 0, 2'd2, 32'h44, 32'h0, 32'hB0);
    checkOutput("t6_accept1", d3RamEn, 1);
    applyStimulus(1, 1, 0, 2'd2, 32'h48, 32'h0, 32'hB1);
    checkOutput("t6_rst_addr_ok", d3AddrOk, 0);
    checkOutput("t6_rst_ram_en", d3RamEn, 0);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("t6_addr_ok_after", d3AddrOk, 1);
    checkOutput("t6_rdata_cleared", d3Rdata, 0);
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("t6_no_data_ok_%0d", k), d3DataOk, 0);
      applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
